way_select_pipe_mux: RTL and testbench

- Pipelined one-hot way-select multiplexer for the set-associative cache read path.
- Takes all way data words plus a one-hot way-select (tag-match vector) and returns the selected word one cycle later.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure from the consumer never drops or duplicates a beat.
- Flags miss (zero-hot) and corrupt select (multi-hot), and keeps a saturating count of multi-hot events for debug.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/skid_buffer.sv | 52 +++++
 rtl/way_select_pipe_mux.sv | 56 +++++
 tb/tb_way_select_pipe_mux.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared cache read-path defaults, beat type and select decode
package cache_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_WAYS = 4;
  localparam int MAX_WAYS = 64;
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic hit;
    logic sel_err;
  } beat_t;
  typedef struct packed {
    logic hit;
    logic err;
  } sel_status_t;
  function automatic sel_status_t onehot_status(input logic [MAX_WAYS-1:0] sel);
    logic [MAX_WAYS-1:0] rest;
    rest = sel & (sel - MAX_WAYS'(1));
    return '{hit: (sel != '0) && (rest == '0), err: rest != '0};
  endfunction
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: registered valid/ready stage with a single skid entry
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic load_out, load_skid, pop_skid;
  logic [WIDTH-1:0] skid_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= EMPTY;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    load_out = 1'b0;
    load_skid = 1'b0;
    pop_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        load_out = i_valid;
        state_d = i_valid ? ONE : EMPTY;
      end
      ONE: begin
        load_out = i_valid && i_ready;
        load_skid = i_valid && !i_ready;
        state_d = load_skid ? FULL : (!i_valid && i_ready) ? EMPTY : ONE;
      end
      default: begin
        pop_skid = i_ready;
        state_d = i_ready ? ONE : FULL;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_data <= '0;
      skid_q <= '0;
    end else begin
      o_data <= load_out ? i_data : pop_skid ? skid_q : o_data;
      skid_q <= load_skid ? i_data : skid_q;
    end
  assign o_valid = state_q != EMPTY;
  assign o_ready = state_q != FULL;
endmodule

// File: rtl/way_select_pipe_mux.sv
// way_select_pipe_mux: pipelined one-hot way-select mux with skid buffer and multi-hot error count
module way_select_pipe_mux
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int WAYS = DEFAULT_WAYS,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WAYS*DATA_WIDTH-1:0] i_data,
  input  logic [WAYS-1:0]            i_sel,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_hit,
  output logic                       o_sel_err,
  input  logic                       i_err_clr,
  output logic [ERR_CNT_WIDTH-1:0]   o_err_cnt
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic hit;
    logic sel_err;
  } way_beat_t;
  sel_status_t st;
  logic [DATA_WIDTH-1:0] sel_data;
  way_beat_t in_beat, out_beat;
  logic accept;
  always_comb begin
    st = onehot_status(MAX_WAYS'(i_sel));
    sel_data = '0;
    for (int k = 0; k < WAYS; k++) sel_data |= i_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{i_sel[k]}};
    in_beat = '{data: st.hit ? sel_data : '0, hit: st.hit, sel_err: st.err};
  end
  skid_buffer #(.WIDTH(DATA_WIDTH + 2)) u_skid (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data(in_beat),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data(out_beat)
  );
  assign accept = i_valid && o_ready;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_err_cnt <= '0;
    else if (i_err_clr) o_err_cnt <= '0;
    else if (accept && in_beat.sel_err && o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_CNT_WIDTH'(1);
  assign o_data = out_beat.data;
  assign o_hit = out_beat.hit;
  assign o_sel_err = out_beat.sel_err;
endmodule

// File: tb/tb_way_select_pipe_mux.sv
// tb_way_select_pipe_mux: directed self-checking bench for way_select_pipe_mux
module tb_way_select_pipe_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  logic i_err_clr = 1'b0;
  logic [3:0] i_sel = 4'b0000;
  logic [127:0] i_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  logic o_ready, o_valid, o_hit, o_sel_err;
  logic [31:0] o_data;
  logic [7:0] o_err_cnt;
  logic o_ready2, o_valid2, o_hit2, o_sel_err2;
  logic [31:0] o_data2;
  logic [1:0] o_err_cnt2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  way_select_pipe_mux dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_sel(i_sel), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_hit(o_hit),
    .o_sel_err(o_sel_err), .i_err_clr(i_err_clr), .o_err_cnt(o_err_cnt)
  );
  way_select_pipe_mux #(.ERR_CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready2), .i_data(i_data),
    .i_sel(i_sel), .o_valid(o_valid2), .i_ready(i_ready), .o_data(o_data2), .o_hit(o_hit2),
    .o_sel_err(o_sel_err2), .i_err_clr(i_err_clr), .o_err_cnt(o_err_cnt2)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string name, input logic v, input logic r, input logic [31:0] d, input logic h, input logic e);
    checks++;
    if ({o_valid, o_ready, o_data, o_hit, o_sel_err} !== {v, r, d, h, e}) begin
      errors++;
      $display("FAIL %s: got v=%b r=%b d=%h hit=%b err=%b expected v=%b r=%b d=%h hit=%b err=%b",
               name, o_valid, o_ready, o_data, o_hit, o_sel_err, v, r, d, h, e);
    end
  endtask
  task automatic test_reset();
    #3;
    chk_out("reset_outputs", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checks++;
    if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", o_err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_onehot();
    i_ready = 1'b1; i_valid = 1'b1; i_sel = 4'b0100;
    step();
    chk_out("onehot_way2", 1'b1, 1'b1, 32'h33333333, 1'b1, 1'b0);
    i_sel = 4'b0001;
    step();
    chk_out("onehot_way0", 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0);
    i_sel = 4'b1000;
    step();
    chk_out("onehot_way3", 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b0);
  endtask
  task automatic test_zero_multi();
    i_sel = 4'b0000;
    step();
    chk_out("zero_sel", 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    checks++;
    if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL zero_cnt: got %0d expected 0", o_err_cnt); end
    i_sel = 4'b0110;
    step();
    chk_out("multi_sel", 1'b1, 1'b1, 32'h0, 1'b0, 1'b1);
    checks++;
    if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL multi_cnt: got %0d expected 1", o_err_cnt); end
    i_valid = 1'b0;
    step();
    chk_out("drain_empty", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
  endtask
  task automatic test_back_to_back();
    i_ready = 1'b0; i_valid = 1'b1; i_sel = 4'b0001;
    step();
    chk_out("bp_A_out", 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0);
    i_sel = 4'b0010;
    step();
    chk_out("bp_B_skid", 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0);
    i_sel = 4'b0100;
    step();
    chk_out("bp_C_stall", 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0);
    i_ready = 1'b1;
    step();
    chk_out("bp_deliver_B", 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b0);
    step();
    chk_out("bp_deliver_C", 1'b1, 1'b1, 32'h33333333, 1'b1, 1'b0);
    i_valid = 1'b0;
    step();
    chk_out("bp_empty", 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0);
    checks++;
    if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL bp_cnt: got %0d expected 1", o_err_cnt); end
  endtask
  task automatic test_err_sat();
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    checks++;
    if (o_err_cnt !== 8'd0 || o_err_cnt2 !== 2'd0) begin
      errors++; $display("FAIL clr_cnt: got %0d/%0d expected 0/0", o_err_cnt, o_err_cnt2);
    end
    i_valid = 1'b1; i_ready = 1'b1; i_sel = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (o_err_cnt2 !== exp2[i] || o_err_cnt !== 8'(i + 1)) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, o_err_cnt2, o_err_cnt, exp2[i], i + 1);
      end
    end
    i_err_clr = 1'b1;
    step();
    checks++;
    if (o_err_cnt !== 8'd0 || o_err_cnt2 !== 2'd0) begin
      errors++; $display("FAIL clr_wins: got %0d/%0d expected 0/0", o_err_cnt, o_err_cnt2);
    end
    i_err_clr = 1'b0;
    step();
    checks++;
    if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL after_clr: got %0d expected 1", o_err_cnt); end
    i_valid = 1'b0;
    step();
  endtask
  task automatic test_async_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_sel = 4'b0001;
    step();
    i_sel = 4'b0010;
    step();
    chk_out("pre_reset_full", 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checks++;
    if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d expected 0", o_err_cnt); end
    #2 rst_n = 1'b1;
    i_ready = 1'b1;
    step();
    chk_out("post_reset_idle", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    i_valid = 1'b1; i_sel = 4'b1000;
    step();
    chk_out("post_reset_beat", 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b0);
    i_valid = 1'b0;
    step();
  endtask
  initial begin
    test_reset();
    step();
    test_onehot();
    test_zero_multi();
    test_back_to_back();
    test_err_sat();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
